neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Sequential reduction stage directly downstream of the neuron multiplier array. Accepts one 33-term signed product vector (32 weighted inputs plus the bias term) per transaction and sums it over several cycles, LANES terms per cycle. Saturates the sum to 32 bits and presents the neuron pre-activation result with a valid/ready handshake to the activation/output stage.

## Interface
Parameters:
- NUM_TERMS, 33, product terms per vector (32 inputs + bias)
- DATA_W, 32, width of each signed product and of the result
- LANES, 4, terms summed per ACCUM cycle; legal range 1..NUM_TERMS

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_products  input  [NUM_TERMS-1:0][DATA_W-1:0]  signed two's-complement products; index 32 is the bias term
- in_valid  input  1  in_products valid
- in_ready  output  1  block can accept a vector
- out_sum  output  DATA_W  saturated signed sum
- out_sat  output  1  saturation occurred for this result
- out_valid  output  1  out_sum/out_sat valid
- out_ready  input  1  consumer accepts result

## Operation
- States: IDLE, ACCUM, DONE. Reset to IDLE, out_sum=0, out_sat=0, out_valid=0, in_ready=1, internal acc=0, idx=0.
- IDLE: in_ready=1. On in_valid && in_ready, latch all terms into the internal buffer, clear acc and idx, go to ACCUM. in_products is not sampled again until the next IDLE.
- ACCUM: in_ready=0. Each cycle, add terms idx..idx+LANES-1 to acc. Terms with index >= NUM_TERMS contribute 0. Then idx += LANES. On the cycle where idx+LANES >= NUM_TERMS, register the final result into out_sum/out_sat and go to DONE.
- DONE: out_valid=1, in_ready=0. out_sum and out_sat are held stable until out_valid && out_ready, then go to IDLE with out_valid=0.
- Arithmetic: acc is ACC_W = DATA_W + clog2(NUM_TERMS) + 1 bits, sign-extended, so no internal wrap is possible. Final result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat=1 when the clamp changed the value.
- rst in any state returns to the reset values on the next edge. Partial sums are discarded and no result is emitted.
- in_valid is ignored outside IDLE. There is no overlap between consecutive vectors.

## Timing
- Accept edge T. ACCUM lasts ceil(NUM_TERMS/LANES) edges. out_valid is high after edge T+ceil(NUM_TERMS/LANES). This is 9 cycles at defaults and 1 with LANES=NUM_TERMS.
- If out_ready is high in the first DONE cycle, in_ready is high the next cycle. Peak throughput is one vector per ceil(NUM_TERMS/LANES)+2 cycles.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- NEURON_ACC_RELU_EN defined: the saturated result passes through ReLU, so negative values give out_sum=0. out_sat still reports the clamp, including negative saturation.
- NEURON_ACC_RELU_EN undefined: out_sum is the signed saturated sum.

## Structure
- Shared package neuron_pkg:
  - NUM_INPUTS=32, NUM_TERMS=33, DATA_W=32, BIAS_INPUT=32'hFFFFFFFE
  - product_vec_t typedef
  - acc_state_t enum {IDLE, ACCUM, DONE}
- One sub-module, neuron_acc_lane_sum: a combinational signed adder that sign-extends LANES DATA_W terms to ACC_W and sums them, with zero-masking for out-of-range indices.
- Elaboration-time check: fail if LANES < 1 or LANES > NUM_TERMS.

## Test plan
- All 33 terms = 1, out_ready=1 → out_valid 9 cycles after accept, out_sum=33, out_sat=0, in_ready high one cycle later.
- Terms alternating 32'h7FFFFFFF / 32'h00000001 → out_sum=32'h7FFFFFFF, out_sat=1. A second vector of all 32'h80000000 → 32'h80000000 and out_sat=1 without NEURON_ACC_RELU_EN, 0 and out_sat=1 with it.
- Terms 0..31 = 2, bias term = -100 → out_sum=-36 without RELU, 0 with RELU.
- out_ready held low 20 cycles in DONE → out_valid, out_sum and out_sat stable, in_ready=0, in_valid pulses ignored. Release → one handshake, then IDLE.
- rst asserted 4 cycles into ACCUM → next cycle IDLE, out_valid=0, in_ready=1. A new vector of all 1s then yields 33.
- LANES=33 build, all terms = -1 → out_valid one cycle after accept, out_sum=-33.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: vector geometry, bias constant,
// accumulator width helper and the accumulator state encoding.
package neuron_pkg;

  localparam int NUM_INPUTS = 32;
  localparam int NUM_TERMS  = NUM_INPUTS + 1;
  localparam int DATA_W     = 32;
  localparam logic [DATA_W-1:0] BIAS_INPUT = 32'hFFFFFFFE;

  // One full set of signed products; the highest index carries the bias term.
  typedef logic [NUM_TERMS-1:0][DATA_W-1:0] product_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

  // Accumulator width that can hold the sum of num_terms signed data_w values
  // without wrapping.
  function automatic int acc_width(input int data_w, input int num_terms);
    return data_w + $clog2(num_terms) + 1;
  endfunction

endpackage

// File: rtl/neuron_acc_lane_sum.sv
// Combinational slice adder: sums the LANES terms starting at base_idx,
// sign-extended to ACC_W. Lanes that fall past the last term contribute zero.
module neuron_acc_lane_sum #(
  parameter int NUM_TERMS = 33,
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int ACC_W     = 39,
  parameter int IDX_W     = 7
) (
  input  logic [NUM_TERMS-1:0][DATA_W-1:0] terms,
  input  logic [IDX_W-1:0]                 base_idx,
  output logic [ACC_W-1:0]                 lane_sum
);

  logic [LANES-1:0][DATA_W-1:0] lane_term;

  // Select the term for each lane; no index match leaves the lane at zero.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_term = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int t = 0; t < NUM_TERMS; t++) begin
        if (base_idx + IDX_W'(l) == IDX_W'(t)) begin
          lane_term[l] = terms[t];
        end
      end
    end
  end

  // Sign-extend each lane to the accumulator width and add them.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + {{(ACC_W-DATA_W){lane_term[l][DATA_W-1]}}, lane_term[l]};
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron pre-activation accumulator. Latches one product vector, sums it LANES
// terms per cycle in a wide accumulator, clamps to DATA_W bits and hands the
// result downstream with valid/ready.
// Build option: define NEURON_ACC_RELU_EN to pass the clamped result through
// a ReLU (negative results become zero; out_sat still reports the clamp).
module neuron_accumulator #(
  parameter int NUM_TERMS = neuron_pkg::NUM_TERMS,
  parameter int DATA_W    = neuron_pkg::DATA_W,
  parameter int LANES     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_TERMS-1:0][DATA_W-1:0] in_products,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_W-1:0]                out_sum,
  output logic                             out_sat,
  output logic                             out_valid,
  input  logic                             out_ready
);

  import neuron_pkg::*;

  localparam int ACC_W = acc_width(DATA_W, NUM_TERMS);
  // idx can reach NUM_TERMS-1+LANES, which is below 2*NUM_TERMS.
  localparam int IDX_W = $clog2(2 * NUM_TERMS);
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (LANES < 1 || LANES > NUM_TERMS) begin : g_bad_lanes
    $error("neuron_accumulator: LANES must lie in 1..NUM_TERMS");
  end

  acc_state_t                       state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [ACC_W-1:0]                 acc_q, acc_d;
  logic [NUM_TERMS-1:0][DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0]                out_sum_q, out_sum_d;
  logic                             out_sat_q, out_sat_d;
  logic                             out_valid_q, out_valid_d;
  logic                             in_ready_q, in_ready_d;

  logic [ACC_W-1:0]  lane_sum;
  logic [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0] res_final;
  logic              sat_hit;

  neuron_acc_lane_sum #(
    .NUM_TERMS (NUM_TERMS),
    .DATA_W    (DATA_W),
    .LANES     (LANES),
    .ACC_W     (ACC_W),
    .IDX_W     (IDX_W)
  ) u_lane_sum (
    .terms    (buf_q),
    .base_idx (idx_q),
    .lane_sum (lane_sum)
  );

  // Running sum including this cycle's slice, clamped (and optionally rectified).
  always_comb begin
    acc_next  = acc_q + lane_sum;
    sat_hit   = 1'b0;
    res_final = acc_next[DATA_W-1:0];
    if ($signed(acc_next) > $signed(SAT_MAX)) begin
      res_final = SAT_MAX[DATA_W-1:0];
      sat_hit   = 1'b1;
    end else if ($signed(acc_next) < $signed(SAT_MIN)) begin
      res_final = SAT_MIN[DATA_W-1:0];
      sat_hit   = 1'b1;
    end
`ifdef NEURON_ACC_RELU_EN
    if (res_final[DATA_W-1]) begin
      res_final = '0;
    end
`endif
  end

  // Next-state and registered-output logic for the IDLE/ACCUM/DONE sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    buf_d       = buf_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          buf_d      = in_products;
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_next;
        idx_d = idx_q + IDX_W'(LANES);
        if (idx_q + IDX_W'(LANES) >= IDX_W'(NUM_TERMS)) begin
          out_sum_d   = res_final;
          out_sat_d   = sat_hit;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Control and result registers with synchronous reset.
  // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Term buffer, loaded only on accept.
  // NOTE: the buffer has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready  = in_ready_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: a LANES=4 instance for the main
// scenarios and a LANES=NUM_TERMS instance for the single-cycle case.
// Expected values follow NEURON_ACC_RELU_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_neuron_accumulator;
  import neuron_pkg::*;

`ifdef NEURON_ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  product_vec_t      in_products;
  logic              in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [DATA_W-1:0] out_sum;

  product_vec_t      in_products_w;
  logic              in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_sat_w;
  logic [DATA_W-1:0] out_sum_w;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(.NUM_TERMS(NUM_TERMS), .DATA_W(DATA_W), .LANES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_products (in_products),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_sum     (out_sum),
    .out_sat     (out_sat),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  neuron_accumulator #(.NUM_TERMS(NUM_TERMS), .DATA_W(DATA_W), .LANES(NUM_TERMS)) dut_wide (
    .clk         (clk),
    .rst         (rst),
    .in_products (in_products_w),
    .in_valid    (in_valid_w),
    .in_ready    (in_ready_w),
    .out_sum     (out_sum_w),
    .out_sat     (out_sat_w),
    .out_valid   (out_valid_w),
    .out_ready   (out_ready_w)
  );

  function automatic product_vec_t fill(input logic [DATA_W-1:0] v);
    product_vec_t r;
    for (int i = 0; i < NUM_TERMS; i++) r[i] = v;
    return r;
  endfunction

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for a single cycle on the LANES=4 instance.
  task automatic accept(input product_vec_t v);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    in_products = v;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
  endtask

  // Count edges until out_valid rises, bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (out_sum !== '0) begin miscompares++; $display("FAIL reset_out_sum: got %h required 0", out_sum); end
    if (out_sat !== 1'b0) begin miscompares++; $display("FAIL reset_out_sat: got %b required 0", out_sat); end
  endtask

  task automatic test_ones();
    int cyc;
    out_ready = 1'b1;
    accept(fill(32'd1));
    wait_valid(cyc);
    vectors += 5;
    if (cyc !== 9) begin miscompares++; $display("FAIL ones_latency: got %0d required 9", cyc); end
    if (out_sum !== 32'd33) begin miscompares++; $display("FAIL ones_sum: got %h required %h", out_sum, 32'd33); end
    if (out_sat !== 1'b0) begin miscompares++; $display("FAIL ones_sat: got %b required 0", out_sat); end
    step();
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ones_in_ready_after: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ones_valid_drop: got %b required 0", out_valid); end
  endtask

  task automatic test_saturation();
    product_vec_t v;
    int cyc;
    for (int i = 0; i < NUM_TERMS; i++) v[i] = (i % 2 == 0) ? 32'h7FFFFFFF : 32'h00000001;
    accept(v);
    wait_valid(cyc);
    vectors += 2;
    if (out_sum !== 32'h7FFFFFFF) begin miscompares++; $display("FAIL pos_sat_sum: got %h required 7fffffff", out_sum); end
    if (out_sat !== 1'b1) begin miscompares++; $display("FAIL pos_sat_flag: got %b required 1", out_sat); end
    step();
    accept(fill(32'h80000000));
    wait_valid(cyc);
    vectors += 2;
    if (out_sum !== (RELU ? 32'h0 : 32'h80000000)) begin
      miscompares++;
      $display("FAIL neg_sat_sum: got %h required %h", out_sum, RELU ? 32'h0 : 32'h80000000);
    end
    if (out_sat !== 1'b1) begin miscompares++; $display("FAIL neg_sat_flag: got %b required 1", out_sat); end
    step();
  endtask

  task automatic test_bias();
    product_vec_t v;
    int cyc;
    v = fill(32'd2);
    v[NUM_TERMS-1] = -32'sd100;
    accept(v);
    wait_valid(cyc);
    vectors += 3;
    if (cyc !== 9) begin miscompares++; $display("FAIL bias_latency: got %0d required 9", cyc); end
    if (out_sum !== (RELU ? 32'h0 : 32'hFFFFFFDC)) begin
      miscompares++;
      $display("FAIL bias_sum: got %h required %h", out_sum, RELU ? 32'h0 : 32'hFFFFFFDC);
    end
    if (out_sat !== 1'b0) begin miscompares++; $display("FAIL bias_sat: got %b required 0", out_sat); end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit spurious;
    out_ready = 1'b0;
    accept(fill(32'd3));
    wait_valid(cyc);
    for (int i = 0; i < 20; i++) begin
      in_products = fill(32'd5);
      in_valid    = (i % 2 == 0);
      step();
      vectors += 4;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b required 1", i, out_valid); end
      if (out_sum !== 32'd99) begin miscompares++; $display("FAIL stall_sum[%0d]: got %h required %h", i, out_sum, 32'd99); end
      if (out_sat !== 1'b0) begin miscompares++; $display("FAIL stall_sat[%0d]: got %b required 0", i, out_sat); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d]: got %b required 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1 || in_ready !== 1'b1) spurious = 1'b1;
    end
    if (spurious !== 1'b0) begin miscompares++; $display("FAIL release_idle_hold: got %b required 0", spurious); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit spurious;
    accept(fill(32'd1));
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
    if (out_sum !== '0) begin miscompares++; $display("FAIL midrst_sum: got %h required 0", out_sum); end
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) spurious = 1'b1;
    end
    if (spurious !== 1'b0) begin miscompares++; $display("FAIL midrst_no_result: got %b required 0", spurious); end
    accept(fill(32'd1));
    wait_valid(cyc);
    vectors += 2;
    if (cyc !== 9) begin miscompares++; $display("FAIL midrst_latency: got %0d required 9", cyc); end
    if (out_sum !== 32'd33) begin miscompares++; $display("FAIL midrst_sum_after: got %h required %h", out_sum, 32'd33); end
    step();
  endtask

  task automatic test_wide_lanes();
    int cyc;
    vectors++;
    if (in_ready_w !== 1'b1) begin miscompares++; $display("FAIL wide_ready: got %b required 1", in_ready_w); end
    in_products_w = fill(32'hFFFFFFFF);
    in_valid_w    = 1'b1;
    step();
    in_valid_w    = 1'b0;
    cyc = 0;
    while (out_valid_w !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    vectors += 3;
    if (cyc !== 1) begin miscompares++; $display("FAIL wide_latency: got %0d required 1", cyc); end
    if (out_sum_w !== (RELU ? 32'h0 : 32'hFFFFFFDF)) begin
      miscompares++;
      $display("FAIL wide_sum: got %h required %h", out_sum_w, RELU ? 32'h0 : 32'hFFFFFFDF);
    end
    if (out_sat_w !== 1'b0) begin miscompares++; $display("FAIL wide_sat: got %b required 0", out_sat_w); end
    step();
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    in_products   = '0;
    in_valid_w    = 1'b0;
    out_ready_w   = 1'b1;
    in_products_w = '0;
    test_reset();
    test_ones();
    test_saturation();
    test_bias();
    test_backpressure();
    test_mid_reset();
    test_wide_lanes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
